// File: rtl/mu0_loader_pkg.sv
// Shared constants and state encoding for the MU0 boot loader (the defs.h values).
// Optional checksum stage is enabled by defining MU0_LOADER_CHECKSUM_EN.
package mu0_loader_pkg;

  localparam int MU0_MAXWIDTH = 16;
  localparam int MU0_MAXDEPTH = 12;
  localparam int BYTE_W       = 8;
  localparam int LEN_W        = 13;
  localparam int MAX_WORDS    = 4096;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LEN_HI = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_DAT_HI = 4'd3,
    ST_DAT_LO = 4'd4,
    ST_WRITE  = 4'd5,
    ST_CHK    = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } loader_state_t;

  // Images larger than the memory are rejected rather than wrapped.
  function automatic logic len_too_big(input logic [LEN_W-1:0] n);
    return n > LEN_W'(MAX_WORDS);
  endfunction

endpackage

// File: rtl/mu0_loader_byte_pack.sv
// Two-byte big-endian word assembler: latches the high byte, presents {hi, data}.
// With MU0_LOADER_CHECKSUM_EN it also keeps a running XOR of accepted bytes.
module mu0_byte_pack
  import mu0_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                hi_load,
`ifdef MU0_LOADER_CHECKSUM_EN
  input  logic                acc_en,
  output logic [BYTE_W-1:0]   xor_acc,
`endif
  input  logic [BYTE_W-1:0]   data,
  output logic [2*BYTE_W-1:0] word
);

  logic [BYTE_W-1:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
    end else if (clear) begin
      hi_q <= '0;
    end else if (hi_load) begin
      hi_q <= data;
    end
  end

  // The low byte is taken straight from the stream on the cycle it transfers.
  assign word = {hi_q, data};

`ifdef MU0_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xor_acc <= '0;
    end else if (clear) begin
      xor_acc <= '0;
    end else if (acc_en) begin
      xor_acc <= xor_acc ^ data;
    end
  end
`endif

endmodule

// File: rtl/mu0_loader.sv
// Boot-time loader: streams a length-prefixed byte image into MU0 memory and
// holds the core in reset until done. Optional checksum: MU0_LOADER_CHECKSUM_EN.
module mu0_loader
  import mu0_loader_pkg::*;
#(
  parameter int MAXWIDTH = MU0_MAXWIDTH,
  parameter int MAXDEPTH = MU0_MAXDEPTH
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic                rx_valid,
  input  logic [BYTE_W-1:0]   rx_data,
  output logic                rx_ready,
  output logic                Wen,
  output logic                Ren,
  output logic [MAXDEPTH-1:0] address,
  output logic [MAXWIDTH-1:0] write_data,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output loader_state_t       fsm_state
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are
  // both high; rx_ready depends only on state, never on rx_valid.

`ifdef MU0_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = ST_CHK;
  logic              acc_en;
  logic [BYTE_W-1:0] xor_acc;
`else
  localparam loader_state_t END_STATE = ST_DONE;
`endif

  loader_state_t        state, next_state;
  logic [LEN_W-1:0]     count, count_inc, word_count;
  logic [2*BYTE_W-1:0]  pack_word;
  logic                 xfer;
  logic                 begin_load, hi_load, len_lo_ld, dat_lo_ld, write_cyc;

  assign fsm_state = state;
  assign Ren       = 1'b0;
  assign rx_ready  = state inside {ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO, ST_CHK};
  assign xfer      = rx_valid & rx_ready;
  assign count_inc = count + 1'b1;

  mu0_byte_pack u_pack (
    .clk     (Clk),
    .rst     (Reset),
    .clear   (begin_load),
    .hi_load (hi_load),
`ifdef MU0_LOADER_CHECKSUM_EN
    .acc_en  (acc_en),
    .xor_acc (xor_acc),
`endif
    .data    (rx_data),
    .word    (pack_word)
  );

`ifdef MU0_LOADER_CHECKSUM_EN
  // The trailing checksum byte itself is not folded into the accumulator.
  assign acc_en = xfer && (state inside {ST_LEN_HI, ST_LEN_LO, ST_DAT_HI, ST_DAT_LO});
`endif

  always_comb begin
    next_state = state;
    Wen        = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    begin_load = 1'b0;
    hi_load    = 1'b0;
    len_lo_ld  = 1'b0;
    dat_lo_ld  = 1'b0;
    write_cyc  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done     = (state == ST_DONE);
        error    = (state == ST_ERR);
        cpu_hold = (state != ST_DONE);
        if (start) begin
          begin_load = 1'b1;
          next_state = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          hi_load    = 1'b1;
          next_state = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_lo_ld = 1'b1;
          if (pack_word[LEN_W-1:0] == '0) begin
            next_state = END_STATE;
          end else if (len_too_big(pack_word[LEN_W-1:0])) begin
            next_state = ST_ERR;
          end else begin
            next_state = ST_DAT_HI;
          end
        end
      end
      ST_DAT_HI: begin
        if (xfer) begin
          hi_load    = 1'b1;
          next_state = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        if (xfer) begin
          dat_lo_ld  = 1'b1;
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        Wen       = 1'b1;
        write_cyc = 1'b1;
        next_state = (count_inc == word_count) ? END_STATE : ST_DAT_HI;
      end
`ifdef MU0_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (xfer) begin
          next_state = (rx_data == xor_acc) ? ST_DONE : ST_ERR;
        end
      end
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      word_count <= '0;
      address    <= '0;
      write_data <= '0;
    end else begin
      state <= next_state;
      if (begin_load) begin
        count <= '0;
      end else if (write_cyc) begin
        count <= count_inc;
      end
      if (len_lo_ld) begin
        word_count <= pack_word[LEN_W-1:0];
      end
      // Address and data settle here so they are stable through the WRITE cycle.
      if (dat_lo_ld) begin
        write_data <= MAXWIDTH'(pack_word);
        address    <= MAXDEPTH'(count);
      end
    end
  end

endmodule

// File: doc/mu0_loader.md
Name: mu0_loader

Overview:
- Boot-time program loader sitting directly upstream of the MU0 memory's write port.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit big-endian words. Writes them to consecutive memory addresses from 0 and holds the MU0 core in reset until the image is complete.
- Replaces file-based preloading of program memory for synthesised builds.

Parameters:
- MAXWIDTH, 16, memory word width (from defs.h; byte assembly fixed to 2 bytes/word)
- MAXDEPTH, 12, memory address width (from defs.h; 4096 words)

Ports:
- Clk  input  1  system clock; all loader state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR (ignored while loading)
- rx_valid  input  1  byte available on rx_data
- rx_data  input  8  stream byte
- rx_ready  output  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready at rising edge)
- Wen  output  1  memory write enable, one-cycle pulse per word
- Ren  output  1  memory read enable, tied 0
- address  output  MAXDEPTH  memory address
- write_data  output  MAXWIDTH  memory write data
- cpu_hold  output  1  holds MU0 core in reset while high
- done  output  1  load completed successfully (level)
- error  output  1  load aborted (level)

Behaviour:
- Reset values: rx_ready=0, Wen=0, Ren=0, address=0, write_data=0, cpu_hold=1, done=0, error=0, state=IDLE.
- Memory captures on the falling edge of Clk. Loader outputs change only on rising edges, so Wen/address/write_data are stable half a cycle before capture.
- Stream format: LEN_HI, LEN_LO (13 valid bits, word count N), then N words as HI, LO bytes. A CHK byte follows only with the optional feature.
- States:
  - IDLE: rx_ready=0. start -> LEN_HI; clears done/error, sets cpu_hold=1, zeroes word counter.
  - LEN_HI / LEN_LO: rx_ready=1; each transfer stores one byte and advances.
  - After LEN_LO: N==0 -> DONE (or CHK), N>4096 -> ERR, else DAT_HI.
  - DAT_HI: rx_ready=1; a transfer latches the high byte -> DAT_LO.
  - DAT_LO: rx_ready=1; a transfer assembles write_data={hi,lo} and sets address=counter -> WRITE.
  - WRITE: rx_ready=0, Wen=1 for exactly one cycle; counter+1. If counter+1==N -> DONE (or CHK), else DAT_HI.
  - DONE: done=1, cpu_hold=0, rx_ready=0; start re-enters LEN_HI.
  - ERR: error=1, cpu_hold=1, rx_ready=0; start re-enters LEN_HI.
- Throughput: 3 cycles per word minimum (2 byte transfers + 1 write cycle). A stalled rx_valid simply waits; there is no timeout.
- Boundaries:
  - N==4096 writes address 0..4095 with no wrap; the 4097th word never occurs.
  - Extra bytes after completion are not accepted (rx_ready=0).
- Reset mid-load aborts immediately to IDLE with cpu_hold=1. Words already written remain in memory.
- start asserted during LEN_HI..WRITE is ignored.
- Wen is never asserted outside WRITE. Ren is always 0.

Optional Feature:
- Macro: MU0_LOADER_CHECKSUM_EN.
- Defined: a running XOR of all bytes from LEN_HI through the last data byte is kept. State CHK (rx_ready=1) accepts one trailing byte: match -> DONE, mismatch -> ERR. Words written before a mismatch remain in memory, but cpu_hold stays 1.
- Undefined: no CHK state; the last WRITE (or N==0) goes straight to DONE.

Decomposition:
- defs.h (shared include) supplies MAXWIDTH and MAXDEPTH plus new localparams for state encodings, max word count 4096, and the stream byte width of 8.
- One natural sub-module: mu0_byte_pack, a 2-byte-to-word assembler with hi/lo latch and XOR accumulator. The FSM stays in mu0_loader.

Test Plan:
- Reset -> cpu_hold=1, done=0, error=0, Wen=0, rx_ready=0. Then start + stream 00 02 12 34 AB CD -> Wen pulses at address 0 (0x1234) and 1 (0xABCD), then done=1, cpu_hold=0.
- start + stream 00 00 -> done=1 with no Wen pulse.
- Length 0x1001 (4097) -> error=1, cpu_hold=1, no writes. Then start + valid 1-word image -> done=1.
- 3-word image with rx_valid toggling 1/0 every cycle -> correct data at addresses 0..2, one Wen per word, rx_ready=0 in every WRITE cycle.
- Reset asserted after the first of 4 words -> state IDLE, cpu_hold=1 immediately (asynchronous). Address 0 written, addresses 1..3 untouched.
- With MU0_LOADER_CHECKSUM_EN: 00 01 12 34 then CHK 0x27 -> done=1. The same image with CHK 0x00 -> error=1, cpu_hold=1.
